// File: rtl/four_bit_serial_sub.sv
// ============================================================================
//  Module      : four_bit_serial_sub
//  Description : Bit-serial borrow-ripple subtractor, d = a - b - bin, LSB
//                first through one full-subtractor cell, start/busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module four_bit_serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int c_CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_r;
    logic [c_CW-1:0]   r_cnt;
    logic              r_br;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_d;
    logic              r_bo;

    logic              w_diff;
    logic              w_bnext;
    logic [WIDTH-1:0]  w_rnext;

    // Single full-subtractor cell operating on the current LSBs.
    assign w_diff  = r_a[0] ^ r_b[0] ^ r_br;
    assign w_bnext = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
    assign w_rnext = {w_diff, r_r[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_bnext;
                    r_r   <= w_rnext;
                    r_cnt <= r_cnt + c_CW'(1);
                    // Results are published only here so d/bo stay stable during RUN.
                    if (r_cnt == c_LAST) begin
                        r_d     <= w_rnext;
                        r_bo    <= w_bnext;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bo   = r_bo;

endmodule

`default_nettype wire

// File: tb/tb_four_bit_serial_sub.sv
// ============================================================================
//  Module      : tb_four_bit_serial_sub
//  Description : Directed self-checking bench for four_bit_serial_sub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_four_bit_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       bin;
    logic       busy, done;
    logic [3:0] d;
    logic       bo;

    logic       start8;
    logic [7:0] a8, b8;
    logic       bin8;
    logic       busy8, done8;
    logic [7:0] d8;
    logic       bo8;

    int n_vec = 0;
    int n_err = 0;

    four_bit_serial_sub #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bo(bo)
    );

    four_bit_serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bo(bo8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic wait_done4(output int busycnt, output bit got);
        busycnt = 0;
        got     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busycnt++;
            @(negedge clk);
        end
    endtask

    task automatic run4(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                        input logic ibin, input logic [3:0] ed, input logic ebo);
        int bc;
        bit got;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(negedge clk);
        start = 1'b0;
        wait_done4(bc, got);
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_busycyc"}, 32'(bc), 32'd4);
        chk({tag, "_d"}, 32'(d), 32'(ed));
        chk({tag, "_bo"}, 32'(bo), 32'(ebo));
        @(negedge clk);
        chk({tag, "_donepulse"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       bin;
        logic [3:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[4] = '{
        '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1},
        '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1},
        '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1},
        '{4'h8, 4'h7, 1'b1, 4'h0, 1'b0}
    };

    initial begin
        int bc, dcnt, last_done, ndone, idx;
        bit got;
        logic [4:0] expq[$];
        logic [4:0] e;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d",    32'(d),    32'd0);
        chk("rst_bo",   32'(bo),   32'd0);
        rst = 1'b0;

        // Basic and directed vectors
        run4("t1", 4'h5, 4'h3, 1'b0, 4'h2, 1'b0);
        foreach (vecs[i])
            run4($sformatf("t2_%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo);

        // Start held while busy and into the done cycle
        @(negedge clk);
        start = 1'b1; a = 4'h9; b = 4'h4; bin = 1'b0;
        dcnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            a = 4'h1; b = 4'h2;
            if (done) dcnt++;
            if (i == 1) chk("t3_d_stable", 32'(d), 32'h0);
        end
        chk("t3_no_early_done", 32'(dcnt), 32'd0);
        @(negedge clk);
        chk("t3_done1", 32'(done), 32'd1);
        chk("t3_d1",    32'(d),    32'h5);
        chk("t3_bo1",   32'(bo),   32'd0);
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("t3_gap", 32'(dcnt), 32'd0);
        chk("t3_done2", 32'(done), 32'd1);
        chk("t3_d2",    32'(d),    32'hF);
        chk("t3_bo2",   32'(bo),   32'd1);

        // Asynchronous reset mid-run, release with start already high
        @(negedge clk);
        start = 1'b1; a = 4'hC; b = 4'h3; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_d",    32'(d),    32'd0);
        chk("t4_bo",   32'(bo),   32'd0);
        start = 1'b1; a = 4'h7; b = 4'h1; bin = 1'b0;
        @(negedge clk);
        chk("t4_done_in_rst", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_accept", 32'(busy), 32'd1);
        wait_done4(bc, got);
        chk("t4_done_new", 32'(got), 32'd1);
        chk("t4_busycyc",  32'(bc),  32'd4);
        chk("t4_d_new",    32'(d),   32'h6);
        chk("t4_bo_new",   32'(bo),  32'd0);

        // Exhaustive back-to-back at maximum rate
        @(negedge clk);
        idx = 0; ndone = 0; last_done = -1;
        for (int cyc = 0; cyc < 512 * 5 + 10; cyc++) begin
            if (done) begin
                ndone++;
                if (expq.size() == 0) begin
                    chk("t5_spurious_done", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("t5_d",  32'(d),  32'(e[3:0]));
                    chk("t5_bo", 32'(bo), 32'(e[4]));
                end
                if (last_done >= 0) chk("t5_period", 32'(cyc - last_done), 32'd5);
                last_done = cyc;
            end
            if (cyc % 5 == 0 && idx < 512) begin
                a = idx[8:5]; b = idx[4:1]; bin = idx[0];
                expq.push_back(5'({1'b0, idx[8:5]}) - 5'(idx[4:1]) - 5'(idx[0]));
                start = 1'b1;
                idx++;
            end else if (idx >= 512) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("t5_done_count", 32'(ndone), 32'd512);

        // WIDTH=8 instance
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        bc = 0; got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                got = 1'b1;
                break;
            end
            if (busy8) bc++;
            @(negedge clk);
        end
        chk("t6_done",    32'(got), 32'd1);
        chk("t6_busycyc", 32'(bc),  32'd8);
        chk("t6_d",       32'(d8),  32'hFF);
        chk("t6_bo",      32'(bo8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
